// File: rtl/sync_fifo_arb_ctrl_if.sv
// Handshake/bus bundle between two write requesters, one reader and the FIFO
// controller, including the RAM-side write/read port signals.
interface sync_fifo_arb_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  // Requester side
  logic                  wr_req0;
  logic [DATA_WIDTH-1:0] wr_data0;
  logic                  wr_gnt0;
  logic                  wr_req1;
  logic [DATA_WIDTH-1:0] wr_data1;
  logic                  wr_gnt1;
  logic                  rd_req;
  logic                  rd_valid;

  // RAM side
  logic                  wclken;
  logic [DATA_WIDTH-1:0] wrdata;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;

  // Status
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  rd_err;
  logic                  wr_err;

  // Controller view
  modport slave (
    input  wr_req0, wr_data0, wr_req1, wr_data1, rd_req,
    output wr_gnt0, wr_gnt1, rd_valid, wclken, wrdata, waddr, raddr,
           full, empty, count, rd_err, wr_err
  );

  // Requester / environment view
  modport master (
    output wr_req0, wr_data0, wr_req1, wr_data1, rd_req,
    input  wr_gnt0, wr_gnt1, rd_valid, wclken, wrdata, waddr, raddr,
           full, empty, count, rd_err, wr_err
  );

endinterface

// File: rtl/sync_fifo_arb_ctrl.sv
// Synchronous FIFO controller with a two-requester round-robin write arbiter.
// Drives an external dual-port RAM (1-cycle registered read port) and keeps
// pointers, occupancy count and sticky error flags.
module sync_fifo_arb_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_fifo_arb_ctrl_if.slave   bus
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } rr_state_e;

  rr_state_e             state_q, state_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_err_q, rd_err_d;
  logic                  wr_err_q, wr_err_d;

  logic                  full_c;
  logic                  empty_c;
  logic                  gnt0_c;
  logic                  gnt1_c;
  logic                  wr_en_c;
  logic                  rd_acc_c;
  logic [DATA_WIDTH-1:0] wrdata_c;

  // Occupancy decode from the registered count
  always_comb begin
    full_c  = (count_q == CW'(DEPTH));
    empty_c = (count_q == '0);
  end

  // Round-robin arbiter: grants and next priority owner
  always_comb begin
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    state_d = state_q;

    // Grants are suppressed while full and while reset is held
    if (rst && !full_c) begin
      if (bus.wr_req0 && bus.wr_req1) begin
        if (state_q == PRI0) begin
          gnt0_c = 1'b1;
        end else begin
          gnt1_c = 1'b1;
        end
      end else begin
        gnt0_c = bus.wr_req0;
        gnt1_c = bus.wr_req1;
      end
    end

    // Priority passes to whichever requester was not served
    if (gnt0_c) begin
      state_d = PRI1;
    end else if (gnt1_c) begin
      state_d = PRI0;
    end
  end

  // Write data steering: granted requester, requester 0 when idle
  always_comb begin
    wrdata_c = bus.wr_data0;
    if (gnt1_c) begin
      wrdata_c = bus.wr_data1;
    end
  end

  // Pointer, count, read-valid and error next-state
  always_comb begin
    wr_en_c    = gnt0_c | gnt1_c;
    rd_acc_c   = bus.rd_req & ~empty_c;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_valid_d = rd_acc_c;
    rd_err_d   = rd_err_q | (bus.rd_req & empty_c);
    wr_err_d   = wr_err_q | ((bus.wr_req0 | bus.wr_req1) & full_c);

    if (wr_en_c) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_acc_c) begin
      rptr_d = rptr_q + AW'(1);
    end

    // Simultaneous read and write leave occupancy unchanged
    unique case ({wr_en_c, rd_acc_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PRI0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Output drive
  assign bus.wr_gnt0  = gnt0_c;
  assign bus.wr_gnt1  = gnt1_c;
  assign bus.wclken   = wr_en_c;
  assign bus.wrdata   = wrdata_c;
  assign bus.waddr    = wptr_q;
  assign bus.raddr    = rptr_q;
  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.count    = count_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_sync_fifo_arb_ctrl.sv
// Self-checking bench for sync_fifo_arb_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model and a RAM model.
module tb_sync_fifo_arb_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;

  sync_fifo_arb_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with registered read port
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata;
  always @(posedge clk) begin
    if (bus.wclken) mem[bus.waddr] <= bus.wrdata;
    rdata <= mem[bus.raddr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: stored words, preferred requester, sticky flags
  logic [DW-1:0] mq[$];
  bit            m_pref1;
  bit            m_rd_err, m_wr_err, m_rvalid;
  logic [DW-1:0] m_rdata;
  int            m_nw, m_nr;

  // Expected and observed values sampled before the edge
  bit            e_g0, e_g1, e_full, e_empty;
  logic [DW-1:0] e_wrdata;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [CW-1:0] e_count;
  logic          o_g0, o_g1, o_wclken, o_full, o_empty;
  logic [DW-1:0] o_wrdata;
  logic [AW-1:0] o_waddr, o_raddr;
  logic [CW-1:0] o_count;

  task automatic model_reset();
    mq.delete();
    m_pref1  = 1'b0;
    m_rd_err = 1'b0;
    m_wr_err = 1'b0;
    m_rvalid = 1'b0;
    m_nw     = 0;
    m_nr     = 0;
  endtask

  task automatic idle_inputs();
    bus.wr_req0 = 1'b0; bus.wr_data0 = '0;
    bus.wr_req1 = 1'b0; bus.wr_data1 = '0;
    bus.rd_req  = 1'b0;
  endtask

  // One clock cycle: apply inputs, sample combinational outputs, advance model
  task automatic cycle(input bit r0, input logic [DW-1:0] d0,
                       input bit r1, input logic [DW-1:0] d1, input bit rd);
    bit acc;
    bus.wr_req0 = r0; bus.wr_data0 = d0;
    bus.wr_req1 = r1; bus.wr_data1 = d1;
    bus.rd_req  = rd;
    #1;
    e_full  = (mq.size() == DEPTH);
    e_empty = (mq.size() == 0);
    e_count = CW'(mq.size());
    e_g0 = 1'b0; e_g1 = 1'b0;
    if (!e_full) begin
      if (r0 && r1) begin
        if (m_pref1) e_g1 = 1'b1; else e_g0 = 1'b1;
      end else begin
        e_g0 = r0; e_g1 = r1;
      end
    end
    e_wrdata = e_g1 ? d1 : d0;
    e_waddr  = AW'(m_nw % DEPTH);
    e_raddr  = AW'(m_nr % DEPTH);
    o_g0 = bus.wr_gnt0; o_g1 = bus.wr_gnt1; o_wclken = bus.wclken;
    o_wrdata = bus.wrdata; o_waddr = bus.waddr; o_raddr = bus.raddr;
    o_full = bus.full; o_empty = bus.empty; o_count = bus.count;
    @(posedge clk);
    acc = rd && !e_empty;
    m_rvalid = acc;
    if (acc) begin
      m_rdata = mq.pop_front();
      m_nr++;
    end
    if (e_g0 || e_g1) begin
      mq.push_back(e_wrdata);
      m_nw++;
      m_pref1 = e_g0;
    end
    if (rd && e_empty) m_rd_err = 1'b1;
    if ((r0 || r1) && e_full) m_wr_err = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    #3;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.wr_req0 = 1'b1; bus.wr_req1 = 1'b1; bus.rd_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.wr_gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0: got %0b expected 0", bus.wr_gnt0); end
    checks++; if (bus.wr_gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1: got %0b expected 0", bus.wr_gnt1); end
    checks++; if (bus.wclken !== 1'b0) begin errors++; $display("FAIL rst_wclken: got %0b expected 0", bus.wclken); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b expected 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b expected 0", bus.full); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL rst_count: got %0d expected 0", bus.count); end
    checks++; if (bus.waddr !== AW'(0) || bus.raddr !== AW'(0)) begin errors++; $display("FAIL rst_addr: got w=%0d r=%0d expected 0/0", bus.waddr, bus.raddr); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0 || bus.wr_err !== 1'b0) begin errors++; $display("FAIL rst_flags: got v=%0b re=%0b we=%0b expected 0", bus.rd_valid, bus.rd_err, bus.wr_err); end
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_then_read();
    do_reset();
    cycle(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    checks++; if (o_g0 !== 1'b1) begin errors++; $display("FAIL wtr_gnt0: got %0b expected 1", o_g0); end
    checks++; if (o_waddr !== AW'(0)) begin errors++; $display("FAIL wtr_waddr: got %0d expected 0", o_waddr); end
    checks++; if (bus.count !== CW'(1)) begin errors++; $display("FAIL wtr_count1: got %0d expected 1", bus.count); end
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL wtr_count0: got %0d expected 0", bus.count); end
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL wtr_rvalid: got %0b expected 1", bus.rd_valid); end
    checks++; if (rdata !== 8'h11) begin errors++; $display("FAIL wtr_rdata: got %0h expected 11", rdata); end
    idle_inputs();
    @(posedge clk); #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL wtr_rvalid_drop: got %0b expected 0", bus.rd_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0);
      checks++; if (o_g0 !== ((i % 2) == 0) || o_g1 !== ((i % 2) == 1)) begin errors++; $display("FAIL rr_gnt[%0d]: got %0b%0b expected %0b%0b", i, o_g1, o_g0, (i % 2) == 1, (i % 2) == 0); end
      checks++; if (o_waddr !== AW'(i)) begin errors++; $display("FAIL rr_waddr[%0d]: got %0d expected %0d", i, o_waddr, i); end
      checks++; if (o_wrdata !== (((i % 2) == 0) ? 8'hA0 : 8'hB0)) begin errors++; $display("FAIL rr_wrdata[%0d]: got %0h", i, o_wrdata); end
    end
    checks++; if (bus.count !== CW'(4)) begin errors++; $display("FAIL rr_count: got %0d expected 4", bus.count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 8'h00, 1'b1, DW'(8'h40 + i), 1'b0);
      if (i < 16) begin
        checks++; if (o_g1 !== 1'b1) begin errors++; $display("FAIL full_gnt[%0d]: got %0b expected 1", i, o_g1); end
      end else begin
        checks++; if (o_g1 !== 1'b0 || o_wclken !== 1'b0) begin errors++; $display("FAIL full_refuse: got gnt=%0b wclken=%0b expected 0", o_g1, o_wclken); end
      end
      if (i == 15) begin
        checks++; if (bus.full !== 1'b1 || bus.count !== CW'(16)) begin errors++; $display("FAIL full_flag: got full=%0b count=%0d expected 1/16", bus.full, bus.count); end
        checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL full_werr_early: got %0b expected 0", bus.wr_err); end
      end
    end
    checks++; if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL full_werr: got %0b expected 1", bus.wr_err); end
  endtask

  task automatic test_simultaneous();
    logic [AW-1:0] w0, r0;
    // Continues from a full FIFO
    cycle(1'b1, 8'hEE, 1'b0, 8'h00, 1'b1);
    checks++; if (o_g0 !== 1'b0) begin errors++; $display("FAIL sim_full_gnt: got %0b expected 0", o_g0); end
    checks++; if (bus.count !== CW'(15)) begin errors++; $display("FAIL sim_full_count: got %0d expected 15", bus.count); end
    checks++; if (bus.rd_valid !== 1'b1 || rdata !== m_rdata) begin errors++; $display("FAIL sim_full_read: got v=%0b d=%0h expected 1/%0h", bus.rd_valid, rdata, m_rdata); end
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checks++; if (bus.count !== CW'(5)) begin errors++; $display("FAIL sim_drain: got %0d expected 5", bus.count); end
    w0 = bus.waddr; r0 = bus.raddr;
    cycle(1'b1, 8'h5C, 1'b0, 8'h00, 1'b1);
    checks++; if (bus.count !== CW'(5)) begin errors++; $display("FAIL sim_count5: got %0d expected 5", bus.count); end
    checks++; if (bus.waddr !== AW'(w0 + 1) || bus.raddr !== AW'(r0 + 1)) begin errors++; $display("FAIL sim_ptrs: got w=%0d r=%0d expected %0d/%0d", bus.waddr, bus.raddr, AW'(w0 + 1), AW'(r0 + 1)); end
    checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL sim_rdata: got %0h expected %0h", rdata, m_rdata); end
  endtask

  task automatic test_empty();
    do_reset();
    cycle(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    checks++; if (o_g0 !== 1'b1) begin errors++; $display("FAIL emp_gnt: got %0b expected 1", o_g0); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL emp_rvalid: got %0b expected 0", bus.rd_valid); end
    checks++; if (bus.rd_err !== 1'b1) begin errors++; $display("FAIL emp_rerr: got %0b expected 1", bus.rd_err); end
    checks++; if (bus.count !== CW'(1)) begin errors++; $display("FAIL emp_count: got %0d expected 1", bus.count); end
    checks++; if (bus.raddr !== AW'(0)) begin errors++; $display("FAIL emp_raddr: got %0d expected 0", bus.raddr); end
  endtask

  task automatic test_wrap_and_midreset();
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      d = DW'($urandom);
      cycle(1'b1, d, 1'b0, 8'h00, 1'b0);
      checks++; if (o_waddr !== AW'(i % DEPTH)) begin errors++; $display("FAIL wrap_waddr[%0d]: got %0d expected %0d", i, o_waddr, i % DEPTH); end
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      checks++; if (o_raddr !== AW'(i % DEPTH) || bus.rd_valid !== 1'b1 || rdata !== d) begin errors++; $display("FAIL wrap_read[%0d]: got ra=%0d v=%0b d=%0h expected %0d/1/%0h", i, o_raddr, bus.rd_valid, rdata, i % DEPTH, d); end
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 8'h00, 1'b1);
    checks++; if (bus.count !== CW'(3) || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: got count=%0d v=%0b expected 3/1", bus.count, bus.rd_valid); end
    bus.wr_req0 = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    checks++; if (bus.count !== CW'(0) || bus.empty !== 1'b1) begin errors++; $display("FAIL mid_count: got count=%0d empty=%0b expected 0/1", bus.count, bus.empty); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %0b expected 0", bus.rd_valid); end
    checks++; if (bus.wr_gnt0 !== 1'b0 || bus.waddr !== AW'(0)) begin errors++; $display("FAIL mid_gnt: got gnt=%0b waddr=%0d expected 0/0", bus.wr_gnt0, bus.waddr); end
    #2;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    // First edge after release acts as a normal cycle
    cycle(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    checks++; if (o_g0 !== 1'b1 || o_waddr !== AW'(0) || bus.count !== CW'(1)) begin errors++; $display("FAIL post_rst: got gnt=%0b waddr=%0d count=%0d expected 1/0/1", o_g0, o_waddr, bus.count); end
  endtask

  task automatic test_random();
    bit r0, r1, rd;
    int wp, rp;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      // Alternate write-heavy and read-heavy phases to visit full and empty
      wp = ((i / 60) % 2 == 0) ? 70 : 25;
      rp = ((i / 60) % 2 == 0) ? 25 : 75;
      r0 = ($urandom_range(0, 99) < wp);
      r1 = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < rp);
      cycle(r0, DW'($urandom), r1, DW'($urandom), rd);
      checks++; if (o_g0 !== e_g0 || o_g1 !== e_g1) begin errors++; $display("FAIL rnd_gnt[%0d]: got %0b%0b expected %0b%0b", i, o_g1, o_g0, e_g1, e_g0); end
      checks++; if (o_wclken !== (e_g0 | e_g1) || o_wrdata !== e_wrdata) begin errors++; $display("FAIL rnd_wr[%0d]: got en=%0b d=%0h expected %0b/%0h", i, o_wclken, o_wrdata, e_g0 | e_g1, e_wrdata); end
      checks++; if (o_waddr !== e_waddr || o_raddr !== e_raddr) begin errors++; $display("FAIL rnd_addr[%0d]: got w=%0d r=%0d expected %0d/%0d", i, o_waddr, o_raddr, e_waddr, e_raddr); end
      checks++; if (o_count !== e_count || o_full !== e_full || o_empty !== e_empty) begin errors++; $display("FAIL rnd_status[%0d]: got c=%0d f=%0b e=%0b expected %0d/%0b/%0b", i, o_count, o_full, o_empty, e_count, e_full, e_empty); end
      checks++; if (bus.rd_valid !== m_rvalid || (m_rvalid && rdata !== m_rdata)) begin errors++; $display("FAIL rnd_read[%0d]: got v=%0b d=%0h expected %0b/%0h", i, bus.rd_valid, rdata, m_rvalid, m_rdata); end
      checks++; if (bus.rd_err !== m_rd_err || bus.wr_err !== m_wr_err) begin errors++; $display("FAIL rnd_err[%0d]: got re=%0b we=%0b expected %0b/%0b", i, bus.rd_err, bus.wr_err, m_rd_err, m_wr_err); end
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_write_then_read();
    test_round_robin();
    test_full();
    test_simultaneous();
    test_empty();
    test_wrap_and_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_arb_ctrl.md
SYNC_FIFO_ARB_CTRL -- requirements
Module: sync_fifo_arb_ctrl

Interface
REQ-001 The block SHALL have these parameters: DATA_WIDTH, default 8, word width; ADDR_WIDTH, default 4, RAM address width; depth = 2**ADDR_WIDTH.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- wr_req0  in  1  requester 0 write request
- wr_data0  in  DATA_WIDTH  requester 0 write data
- wr_gnt0  out  1  requester 0 write accepted this cycle
- wr_req1  in  1  requester 1 write request
- wr_data1  in  DATA_WIDTH  requester 1 write data
- wr_gnt1  out  1  requester 1 write accepted this cycle
- rd_req  in  1  read request
- rd_valid  out  1  RAM rdata holds the accepted read word this cycle
- wclken  out  1  RAM write enable
- wrdata  out  DATA_WIDTH  RAM write data
- waddr  out  ADDR_WIDTH  RAM write address
- raddr  out  ADDR_WIDTH  RAM read address
- full  out  1  count == depth
- empty  out  1  count == 0
- count  out  ADDR_WIDTH+1  stored words
- rd_err  out  1  sticky; read attempted while empty
- wr_err  out  1  sticky; write request refused because full

Function
REQ-003 The block SHALL drive a dual-port RAM with one write port (wclken/wrdata/waddr) and one registered read port with 1-cycle latency (raddr sampled on the edge, rdata valid after it).
REQ-004 The block SHALL keep the state wptr, rptr (ADDR_WIDTH bits, wrapping depth-1 -> 0), count (ADDR_WIDTH+1 bits), a round-robin FSM, rd_valid, rd_err and wr_err.
REQ-005 The round-robin FSM SHALL have two states: PRI0 (requester 0 has priority) and PRI1.
REQ-006 Grants SHALL be combinational from registered state and requests, with no grant while full.
REQ-007 With one requester active and not full, that requester SHALL be granted.
REQ-008 With both requesters active and not full, the priority owner SHALL be granted, and the FSM SHALL move to the other state at the next edge.
REQ-009 A single-requester grant SHALL move the FSM to the state favouring the non-granted requester.
REQ-010 With no grant, the FSM SHALL hold its state.
REQ-011 wr_gnt0 and wr_gnt1 SHALL never both be 1.
REQ-012 wclken SHALL equal wr_gnt0|wr_gnt1.
REQ-013 wrdata SHALL be the granted requester's data, and wr_data0 when there is no grant.
REQ-014 waddr SHALL be wptr.
REQ-015 On wclken, wptr SHALL increment at the edge.
REQ-016 A read SHALL be accepted when rd_req=1 and empty=0.
REQ-017 raddr SHALL be rptr.
REQ-018 On an accepted read, rptr SHALL increment at the edge, and rd_valid SHALL be 1 in the following cycle only.
REQ-019 rd_valid SHALL be registered, with latency exactly 1 cycle from the accepting cycle.
REQ-020 Count update: +1 on write only, -1 on read only, unchanged when both or neither occur.
REQ-021 full and empty SHALL be decoded from registered count, so they are combinational outputs of state.
REQ-022 When full, write requests SHALL be refused even if a read is accepted in the same cycle, and wr_err SHALL set.
REQ-023 When empty, rd_req SHALL be ignored, rd_valid SHALL stay 0 next cycle and rd_err SHALL set; a simultaneous write SHALL still be accepted.
REQ-024 Write and read to the same address SHALL never both be accepted in one cycle, since this requires count 0 or depth.
REQ-025 rd_err and wr_err SHALL clear only on reset.

Reset
REQ-026 While rst=0, asynchronously, the block SHALL force wptr=0, rptr=0, count=0 and FSM=PRI0.
REQ-027 While rst=0, asynchronously, the block SHALL force rd_valid=0, rd_err=0 and wr_err=0.
REQ-028 During reset, outputs SHALL be: empty=1, full=0, wclken=0, wr_gnt0/1=0, waddr=raddr=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored words, and the in-flight rd_valid SHALL be cleared immediately.
REQ-030 The first edge after rst deasserts SHALL behave as a normal cycle.

Verification
REQ-031 Scenario, write-then-read: reset, wr_req0 with data 0x11 for 1 cycle, then rd_req 1 cycle -> wr_gnt0=1 and waddr=0; count 1 then 0; rd_valid=1 the cycle after the read; RAM rdata=0x11.
REQ-032 Scenario, round-robin: both requesters held with data 0xA0 and 0xB0 for 4 cycles from PRI0 -> grants 0,1,0,1; waddr 0..3; count=4.
REQ-033 Scenario, full: 17 writes from requester 1 at depth 16 -> grants on 16 cycles; full=1 and count=16 after the 16th; 17th refused with wr_err=1.
REQ-034 Scenario, simultaneous access: at full, rd_req plus wr_req0 -> read accepted, write refused, count=15. At count=5, read plus write -> count stays 5, both pointers advance.
REQ-035 Scenario, empty: rd_req on an empty FIFO together with wr_req0 -> write accepted, no rd_valid, rd_err=1, count=1.
REQ-036 Scenario, wrap-around and mid-op reset: 20 writes interleaved with 20 reads -> pointers wrap 15->0 and data order is preserved; then with 3 words stored, assert rst mid-cycle -> count=0, empty=1 and rd_valid=0 immediately.
